// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds, count, error flags and flush
module sync_fifo_prog #(
    parameter int DATASIZE = 128,
    parameter int ADDRSIZE = 4,
    parameter int AF_LEVEL = 2**ADDRSIZE - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                w_en,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                r_en,
    output logic [DATASIZE-1:0] rdata,
    output logic                r_valid,
    output logic                w_full,
    output logic                r_empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 2**ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AF_C    = (ADDRSIZE+1)'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] AE_C    = (ADDRSIZE+1)'(AE_LEVEL);
    localparam logic [ADDRSIZE:0] ONE_C   = (ADDRSIZE+1)'(1);

    logic [DATASIZE-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit; the low bits address the memory.
    logic [ADDRSIZE:0]   w_ptr;
    logic [ADDRSIZE:0]   r_ptr;
    logic [ADDRSIZE-1:0] w_addr;
    logic [ADDRSIZE-1:0] r_addr;
    logic                wr_ok;
    logic                rd_ok;
    logic [ADDRSIZE:0]   count_next;

    assign w_addr = w_ptr[ADDRSIZE-1:0];
    assign r_addr = r_ptr[ADDRSIZE-1:0];

    // Acceptance uses the registered (pre-edge) flags, so a full FIFO
    // rejects a write even when a read frees a slot in the same cycle.
    assign wr_ok = w_en & ~w_full;
    assign rd_ok = r_en & ~r_empty;

    assign count_next = count + {{ADDRSIZE{1'b0}}, wr_ok} - {{ADDRSIZE{1'b0}}, rd_ok};

    // Storage write; a flush suppresses the write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[w_addr] <= wdata;
        end
    end

    // Pointers, occupancy, status flags and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            w_full       <= 1'b0;
            r_empty      <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            w_full       <= 1'b0;
            r_empty      <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + ONE_C;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + ONE_C;
            end
            count        <= count_next;
            w_full       <= (count_next == DEPTH_C);
            r_empty      <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            if (w_en && w_full) begin
                overflow <= 1'b1;
            end
            if (r_en && r_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT == 0) begin : g_std
        logic [DATASIZE-1:0] rdata_q;
        logic                r_valid_q;

        // Registered read: a popped word appears one edge after its r_en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q   <= '0;
                r_valid_q <= 1'b0;
            end else if (clr) begin
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= rd_ok;
                if (rd_ok) begin
                    rdata_q <= mem[r_addr];
                end
            end
        end

        assign rdata   = rdata_q;
        assign r_valid = r_valid_q;
    end else begin : g_fwft
        // Head word is presented directly; r_en acts as the acknowledge.
        assign rdata   = r_empty ? '0 : mem[r_addr];
        assign r_valid = ~r_empty;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - self-checking bench for sync_fifo_prog in standard and FWFT modes
module tb_sync_fifo_prog;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       w_en;
    logic [7:0] wdata;
    logic       r_en;

    logic [7:0] rd0, rd1;
    logic       rv0, rv1, full0, full1, empty0, empty1;
    logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [4:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a queue of stored words plus last popped word.
    logic [7:0] q[$];
    logic       ovf_m, unf_m, rv_m;
    logic [7:0] rd_m;

    sync_fifo_prog #(.DATASIZE(8), .ADDRSIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .rdata(rd0), .r_valid(rv0), .w_full(full0), .r_empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_prog #(.DATASIZE(8), .ADDRSIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .rdata(rd1), .r_valid(rv1), .w_full(full1), .r_empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        rv_m  = 1'b0;
        rd_m  = 8'h00;
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic c);
        int n;
        n = q.size();
        if (c) begin
            q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
            rv_m  = 1'b0;
        end else begin
            rv_m = 1'b0;
            if (w && n == DEPTH) ovf_m = 1'b1;
            if (r && n == 0)     unf_m = 1'b1;
            if (r && n > 0) begin
                rd_m = q.pop_front();
                rv_m = 1'b1;
            end
            if (w && n < DEPTH) q.push_back(d);
        end
    endtask

    // Drive one cycle: inputs settle after the previous edge, the model
    // advances at the edge, and the task returns just after it.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        w_en  = w;
        wdata = d;
        r_en  = r;
        @(posedge clk);
        model_step(w, d, r, clr);
        #1;
    endtask

    // Every-cycle comparison of both DUTs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cnt_std",   cnt0,   q.size());
            chk("cnt_fwft",  cnt1,   q.size());
            chk("full_std",  full0,  q.size() == DEPTH);
            chk("full_fwft", full1,  q.size() == DEPTH);
            chk("empty_std", empty0, q.size() == 0);
            chk("empty_fwft",empty1, q.size() == 0);
            chk("af_std",    af0,    q.size() >= 14);
            chk("af_fwft",   af1,    q.size() >= 14);
            chk("ae_std",    ae0,    q.size() <= 2);
            chk("ae_fwft",   ae1,    q.size() <= 2);
            chk("ovf_std",   ovf0,   ovf_m);
            chk("ovf_fwft",  ovf1,   ovf_m);
            chk("unf_std",   unf0,   unf_m);
            chk("unf_fwft",  unf1,   unf_m);
            chk("rv_std",    rv0,    rv_m);
            chk("rd_std",    rd0,    rd_m);
            chk("rv_fwft",   rv1,    q.size() != 0);
            if (q.size() != 0) chk("rd_fwft", rd1, q[0]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        logic [7:0] nxt;
        rst = 1'b1; clr = 1'b0; w_en = 1'b0; wdata = 8'h00; r_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cnt",   cnt0,   0);
        chk("reset_empty", empty0, 1);
        chk("reset_ae",    ae0,    1);
        chk("reset_rd",    rd0,    0);
        rst = 1'b0;

        // Fill 0x00..0x0F, watching thresholds as count climbs.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i == 1)  chk("ae_at2",  ae0, 1);
            if (i == 2)  chk("ae_at3",  ae0, 0);
            if (i == 12) chk("af_at13", af0, 0);
            if (i == 13) chk("af_at14", af0, 1);
        end
        chk("fill_full", full0, 1);
        chk("fill_cnt",  cnt0,  16);

        // Write while full: overflow, count unchanged.
        cyc(1'b1, 8'hEE, 1'b0);
        chk("ovf_set",  ovf0, 1);
        chk("ovf_cnt",  cnt0, 16);
        chk("ovf_head", rd1,  8'h00);

        // Drain in order with one-cycle latency in standard mode.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_rv", rv0, 1);
            chk("drain_rd", rd0, 8'(i));
        end
        chk("drain_empty", empty0, 1);
        chk("drain_cnt",   cnt0,   0);

        // Read while empty: underflow, no valid.
        cyc(1'b0, 8'h00, 1'b1);
        chk("unf_set", unf0, 1);
        chk("unf_rv",  rv0,  0);
        cyc(1'b0, 8'h00, 1'b0);

        // Flush clears errors and wins over a same-cycle write.
        cyc(1'b1, 8'h11, 1'b0);
        clr = 1'b1;
        cyc(1'b1, 8'h12, 1'b1);
        clr = 1'b0;
        chk("clr_ovf", ovf0, 0);
        chk("clr_unf", unf0, 0);
        chk("clr_cnt", cnt0, 0);

        // Simultaneous read/write at count 5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'h30 + 8'(i), 1'b1);
            chk("rw5_cnt", cnt0, 5);
        end
        chk("rw5_last", rd0, 8'h34);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("rw5_tail", rd0, 8'h39);

        // Simultaneous at full: read wins, write rejected.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
        cyc(1'b1, 8'hFF, 1'b1);
        chk("rwfull_cnt", cnt0, 15);
        chk("rwfull_ovf", ovf0, 1);
        clr = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        clr = 1'b0;

        // Simultaneous at empty: write wins, read rejected.
        cyc(1'b1, 8'h77, 1'b1);
        chk("rwempty_cnt", cnt0, 1);
        chk("rwempty_unf", unf0, 1);
        chk("rwempty_rv",  rv0,  0);
        clr = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        clr = 1'b0;

        // FWFT: a word written into an empty FIFO is visible without r_en.
        cyc(1'b1, 8'hA5, 1'b0);
        chk("fwft_empty", empty1, 0);
        chk("fwft_rd",    rd1,    8'hA5);
        cyc(1'b0, 8'h00, 1'b0);
        chk("fwft_hold",  rd1,    8'hA5);
        cyc(1'b0, 8'h00, 1'b1);
        chk("fwft_pop",   empty1, 1);

        // Wraparound: 40 words with random gaps on both sides.
        pushed = 0;
        nxt = 8'h80;
        for (int k = 0; k < 400 && (pushed < 40 || q.size() > 0); k++) begin
            logic w, r;
            w = (pushed < 40) && ($urandom_range(0, 2) != 0);
            r = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            cyc(w, nxt, r);
            if (w && q.size() <= DEPTH && !full0) begin
                pushed++;
                nxt = nxt + 8'h01;
            end
        end
        chk("wrap_pushed", pushed, 40);
        cyc(1'b0, 8'h00, 1'b0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
        cyc(1'b1, 8'hC3, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_cnt0",   cnt0,   0);
        chk("arst_empty0", empty0, 1);
        chk("arst_full0",  full0,  0);
        chk("arst_ae0",    ae0,    1);
        chk("arst_rv0",    rv0,    0);
        chk("arst_rd0",    rd0,    0);
        chk("arst_cnt1",   cnt1,   0);
        chk("arst_rv1",    rv1,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 8'h5C, 1'b0);
        chk("post_rst_fwft", rd1, 8'h5C);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_std",  rd0, 8'h5C);
        chk("post_rst_rv",   rv0, 1);
        cyc(1'b0, 8'h00, 1'b0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Single-clock successor to the dual-clock FIFO top, for paths where producer and consumer share a clock and no pointer synchronisers are needed.
- Parametrised in width and depth, with two read modes: standard registered-read and first-word-fall-through (FWFT).
- Adds a programmable almost-full/almost-empty threshold, an occupancy count, sticky overflow/underflow error flags and a synchronous flush.
- Sits between streaming datapath stages inside one clock domain.

Parameters:
- DATASIZE, 128, data word width in bits.
- ADDRSIZE, 4, address bits; DEPTH = 2**ADDRSIZE entries.
- AF_LEVEL, 2**ADDRSIZE-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush; empties the FIFO and clears the error flags.
- w_en  in  1  write request.
- wdata  in  DATASIZE  write data.
- r_en  in  1  read (pop) request.
- rdata  out  DATASIZE  read data.
- r_valid  out  1  standard mode: rdata holds a popped word this cycle. FWFT mode: equals ~r_empty.
- w_full  out  1  FIFO holds DEPTH words.
- r_empty  out  1  FIFO holds 0 words.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDRSIZE+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset: rst is asynchronous and active-high. On assertion: pointers=0, count=0, r_empty=1, w_full=0, almost_empty=1, almost_full=0, r_valid=0, rdata=0, overflow=0, underflow=0. Memory contents are not reset.
- Pointers: w_ptr and r_ptr are ADDRSIZE+1 bits wide (extra wrap bit); memory address is the low ADDRSIZE bits.
  - empty when w_ptr == r_ptr.
  - full when the MSBs differ and the low bits are equal.
  - Wrap from DEPTH-1 to 0 is natural binary rollover.
- Write acceptance: wr_ok = w_en & ~w_full.
  - Memory is written at the edge.
  - w_ptr increments.
- Read acceptance: rd_ok = r_en & ~r_empty.
  - r_ptr increments.
- Flags and count: all are registered and reflect state after the current edge.
  - count_next = count + wr_ok - rd_ok.
  - w_full, r_empty, almost_full and almost_empty are derived from count_next.
- Simultaneous events:
  - Full plus w_en plus r_en: the read is accepted, the write is rejected (flags use pre-edge state) and overflow sets.
  - Empty plus w_en plus r_en: the write is accepted, the read is rejected and underflow sets.
  - Otherwise both are accepted and count is unchanged.
- Standard mode (FWFT=0):
  - On rd_ok, rdata <= mem[r_addr] and r_valid=1 at the next edge (latency 1).
  - Otherwise r_valid=0 and rdata holds its last value.
- FWFT mode (FWFT=1):
  - rdata = mem[r_addr] combinationally while ~r_empty; r_en acknowledges and pops the head.
  - A word written into an empty FIFO at edge N is visible on rdata with r_empty=0 after edge N.
- Error flags:
  - overflow sets on w_en & w_full.
  - underflow sets on r_en & r_empty.
  - Both stay set until rst or clr.
- clr:
  - Has priority over w_en and r_en in the same cycle.
  - Next state equals the reset state, except memory and, in standard mode, rdata are left unchanged.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first accepted write after deassertion goes to address 0.

Test Plan:
- Fill then drain, FWFT=0, ADDRSIZE=4: write 0x00..0x0F over 16 cycles.
  - w_full=1 after the 16th edge with count=16.
  - 16 reads return 0x00..0x0F, each with r_valid one cycle after r_en.
  - r_empty=1 and count=0 at the end.
- Thresholds, AF_LEVEL=14, AE_LEVEL=2:
  - almost_full rises at the edge where count becomes 14.
  - almost_empty falls at the edge where count becomes 3.
- Error flags:
  - A 17th write while full sets overflow; count stays 16 and the memory head is unchanged.
  - A read while empty sets underflow; r_valid stays 0.
  - clr clears both flags and sets count=0.
- Simultaneous read/write:
  - At count=5, w_en=r_en=1 for 10 cycles: count stays 5 and the data order is preserved.
  - At full: count becomes 15 and overflow=1.
  - At empty: count becomes 1 and underflow=1.
- FWFT=1: write 0xA5 into the empty FIFO.
  - Next cycle r_empty=0 and rdata=0xA5 with no r_en.
  - r_en pops it and r_empty=1 after that edge.
- Wrap and reset:
  - Push/pop 40 words with random gaps and check pointer wraparound ordering.
  - Assert rst mid-stream (between edges): outputs go to reset values before the next edge.
  - The next write after deassertion is readable as the first word.
